// File: rtl/key_timer.sv
// key_timer: key-driven run/pause interval timer with tick strobe and wrapping event count
module key_timer #(
    parameter int DIV_BASE = 5_000_000,
    parameter int COUNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key0,
    input  logic               key_interval,
    output logic               tick,
    output logic [COUNT_W-1:0] count,
    output logic               running,
    output logic [1:0]         interval_sel
);
    localparam int PW = $clog2(8 * DIV_BASE);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    state_t        state;
    logic [PW-1:0] pre;
    logic [PW-1:0] last;

    assign last    = PW'((DIV_BASE << interval_sel) - 1);
    assign running = (state == RUN);

    // clear beats interval step beats run control beats counting; a step discards a same-edge terminal count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pre          <= '0;
            count        <= '0;
            interval_sel <= '0;
            tick         <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (key0 && key_interval) begin
                state        <= IDLE;
                pre          <= '0;
                count        <= '0;
                interval_sel <= '0;
            end else if (key_interval) begin
                interval_sel <= interval_sel + 2'd1;
                pre          <= '0;
            end else if (key0) begin
                state <= (state == RUN) ? PAUSED : RUN;
            end else if (state == RUN) begin
                if (pre == last) begin
                    pre   <= '0;
                    count <= count + 1'b1;
                    tick  <= 1'b1;
                end else begin
                    pre <= pre + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_key_timer.sv
// tb_key_timer: directed checks of key_timer run control, interval stepping, wrap, clear and async reset
module tb_key_timer;
    logic       clk = 1'b0;
    logic       rst;
    logic       key0;
    logic       key_interval;
    logic       tick;
    logic [3:0] count;
    logic       running;
    logic [1:0] interval_sel;
    int         checks = 0;
    int         failures = 0;

    key_timer #(.DIV_BASE(4), .COUNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .key0         (key0),
        .key_interval (key_interval),
        .tick         (tick),
        .count        (count),
        .running      (running),
        .interval_sel (interval_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic k0, input logic ki);
        key0         = k0;
        key_interval = ki;
        @(negedge clk);
        key0         = 1'b0;
        key_interval = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tick"}, 32'(tick), 0);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_run"}, 32'(running), 0);
        chk({tag, "_isel"}, 32'(interval_sel), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        key0 = 1'b0;
        key_interval = 1'b0;
        cyc(2);
        chk_zero("reset");
        rst = 1'b0;
        cyc(1);

        // start: ticks after edges 4, 8, 12
        press(1, 0);
        chk("start_run", 32'(running), 1);
        chk("start_tick0", 32'(tick), 0);
        cyc(3);
        chk("pre_tick1", 32'(tick), 0);
        cyc(1);
        chk("tick1", 32'(tick), 1);
        chk("count1", 32'(count), 1);
        cyc(1);
        chk("tick1_one_cycle", 32'(tick), 0);
        chk("count1_hold", 32'(count), 1);
        cyc(3);
        chk("tick2", 32'(tick), 1);
        chk("count2", 32'(count), 2);
        cyc(4);
        chk("tick3", 32'(tick), 1);
        chk("count3", 32'(count), 3);
        press(1, 1);
        chk_zero("clear1");

        // interval steps while idle, then 32-cycle period
        press(0, 1);
        press(0, 1);
        press(0, 1);
        chk("isel3", 32'(interval_sel), 3);
        chk("isel3_idle", 32'(running), 0);
        press(1, 0);
        cyc(31);
        chk("p32_pre", 32'(tick), 0);
        cyc(1);
        chk("p32_tick1", 32'(tick), 1);
        chk("p32_count1", 32'(count), 1);
        cyc(32);
        chk("p32_tick2", 32'(tick), 1);
        chk("p32_count2", 32'(count), 2);
        press(0, 1);
        chk("isel_wrap", 32'(interval_sel), 0);
        chk("isel_wrap_run", 32'(running), 1);
        press(1, 1);
        chk_zero("clear2");

        // pause with prescaler 2 held, resume continues the partial period
        press(1, 0);
        cyc(2);
        press(1, 0);
        chk("paused", 32'(running), 0);
        cyc(19);
        chk("paused_tick", 32'(tick), 0);
        chk("paused_count", 32'(count), 0);
        press(1, 0);
        chk("resumed", 32'(running), 1);
        cyc(1);
        chk("resume_pre", 32'(tick), 0);
        cyc(1);
        chk("resume_tick", 32'(tick), 1);
        chk("resume_count", 32'(count), 1);
        press(1, 1);
        chk_zero("clear3");

        // count wrap, then an interval step on the terminal edge
        press(1, 0);
        cyc(60);
        chk("count15", 32'(count), 15);
        cyc(4);
        chk("wrap_tick", 32'(tick), 1);
        chk("wrap_count", 32'(count), 0);
        cyc(3);
        press(0, 1);
        chk("term_step_tick", 32'(tick), 0);
        chk("term_step_count", 32'(count), 0);
        chk("term_step_isel", 32'(interval_sel), 1);
        cyc(7);
        chk("p8_pre", 32'(tick), 0);
        cyc(1);
        chk("p8_tick", 32'(tick), 1);
        chk("p8_count", 32'(count), 1);

        // simultaneous keys mid-period with count 5 and interval 2
        press(0, 1);
        cyc(64);
        chk("p16_count5", 32'(count), 5);
        chk("p16_isel2", 32'(interval_sel), 2);
        cyc(3);
        press(1, 1);
        chk_zero("both_keys");
        cyc(20);
        chk("idle_no_tick", 32'(tick), 0);
        chk("idle_count", 32'(count), 0);

        // asynchronous reset mid-period
        press(1, 0);
        cyc(2);
        chk("pre_rst_run", 32'(running), 1);
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        cyc(1);
        press(1, 0);
        cyc(3);
        chk("rst_restart_pre", 32'(tick), 0);
        cyc(1);
        chk("rst_restart_tick", 32'(tick), 1);
        chk("rst_restart_count", 32'(count), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
